module_sclk_gen: RTL and testbench

SPI serial-clock generator feeding the SPI master control FSM. Divides clk_i into SCLK while en_sclk_i is held. Emits single-cycle pos_edge_o/neg_edge_o strobes, aligned with each SCLK transition, which the control FSM uses to time TX shift, RX sample and bit counting. Guarantees SCLK always parks at its idle level, with no glitches and no runt phases, when enable drops.

---
 rtl/spi_pkg.sv | 5 +
 rtl/module_sclk_gen.sv | 82 ++++++++
 tb/tb_module_sclk_gen.sv | 137 +++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared types and defaults for the SPI master blocks
package spi_pkg;
    typedef enum logic [1:0] {IDLE, LOW, HIGH} sclk_state_t;
    localparam int SCLK_DIV_HALF_DEF = 4;
endpackage

// File: rtl/module_sclk_gen.sv
// module_sclk_gen: divides clk_i into a glitch-free SCLK with leading/trailing edge strobes
// Optional SPI_SCLK_CPOL_EN adds cpol_i, latched in IDLE, selecting the SCLK idle level
module module_sclk_gen
    import spi_pkg::*;
#(
    parameter int DIV_HALF = SCLK_DIV_HALF_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_sclk_i,
`ifdef SPI_SCLK_CPOL_EN
    input  logic cpol_i,
`endif
    output logic sclk_o,
    output logic pos_edge_o,
    output logic neg_edge_o,
    output logic busy_o
);
    localparam int CNT_W = $clog2(DIV_HALF);
    sclk_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic sclk_q, sclk_d, pos_d, neg_d, last;
    assign last = cnt_q == CNT_W'(DIV_HALF - 1);
    assign busy_o = state_q != IDLE;
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sclk_q     <= 1'b0;
            pos_edge_o <= 1'b0;
            neg_edge_o <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sclk_q     <= sclk_d;
            pos_edge_o <= pos_d;
            neg_edge_o <= neg_d;
        end
    end
    // An enable drop in HIGH is only honoured at the end of the half, so no runt high phase
    always_comb begin
        state_d = IDLE;
        cnt_d   = '0;
        sclk_d  = 1'b0;
        pos_d   = 1'b0;
        neg_d   = 1'b0;
        case (state_q)
            IDLE: state_d = en_sclk_i ? LOW : IDLE;
            LOW: begin
                if (en_sclk_i && last) begin
                    state_d = HIGH;
                    sclk_d  = 1'b1;
                    pos_d   = 1'b1;
                end else if (en_sclk_i) begin
                    state_d = LOW;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            HIGH: begin
                if (!last) begin
                    state_d = HIGH;
                    cnt_d   = cnt_q + 1'b1;
                    sclk_d  = 1'b1;
                end else begin
                    state_d = en_sclk_i ? LOW : IDLE;
                    neg_d   = en_sclk_i;
                end
            end
            default: state_d = IDLE;
        endcase
    end
`ifdef SPI_SCLK_CPOL_EN
    logic cpol_q;
    always_ff @(posedge clk_i) begin
        if (!rst_i) cpol_q <= 1'b0;
        else if (state_q == IDLE) cpol_q <= cpol_i;
    end
    assign sclk_o = sclk_q ^ cpol_q;
`else
    assign sclk_o = sclk_q;
`endif
endmodule

// File: tb/tb_module_sclk_gen.sv
// tb_module_sclk_gen: directed checks of module_sclk_gen with DIV_HALF=4
module tb_module_sclk_gen;
    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    logic en_sclk_i = 1'b0;
    logic sclk_o, pos_edge_o, neg_edge_o, busy_o;
    int vectors = 0;
    int miscompares = 0;
`ifdef SPI_SCLK_CPOL_EN
    logic cpol_i = 1'b0;
`endif
    module_sclk_gen #(.DIV_HALF(4)) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .en_sclk_i(en_sclk_i),
`ifdef SPI_SCLK_CPOL_EN
        .cpol_i(cpol_i),
`endif
        .sclk_o(sclk_o),
        .pos_edge_o(pos_edge_o),
        .neg_edge_o(neg_edge_o),
        .busy_o(busy_o)
    );
    always #5 clk_i = ~clk_i;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask
    function automatic logic [3:0] outs();
        return {sclk_o, pos_edge_o, neg_edge_o, busy_o};
    endfunction
    task automatic go_idle();
        en_sclk_i = 1'b0;
        rst_i = 1'b0;
        step(1);
        rst_i = 1'b1;
    endtask
    initial begin
        int pos_n, neg_n;
        logic [3:0] e;
        // reset held with enable high: everything quiet
        en_sclk_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("reset_outs", outs(), 4'b0000);
        end
        rst_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step(1);
            chk("first_low", outs(), 4'b0001);
        end
        step(1);
        chk("first_pos", outs(), 4'b1101);
        // continuous run, closed-form expectation per edge
        go_idle();
        en_sclk_i = 1'b1;
        pos_n = 0;
        neg_n = 0;
        for (int i = 1; i <= 66; i++) begin
            step(1);
            e[3] = i >= 5 && ((i - 5) % 8) < 4;
            e[2] = i >= 5 && ((i - 5) % 8) == 0;
            e[1] = i >= 9 && ((i - 9) % 8) == 0;
            e[0] = 1'b1;
            chk("run", outs(), e);
            pos_n += int'(pos_edge_o);
            neg_n += int'(neg_edge_o);
        end
        chk("pos_count", pos_n, 8);
        chk("neg_count", neg_n, 8);
        en_sclk_i = 1'b0;
        step(1);
        chk("run_stop", outs(), 4'b0000);
        // drop two cycles into HIGH: full high half, no neg strobe
        en_sclk_i = 1'b1;
        step(5);
        chk("abort_pos", outs(), 4'b1101);
        step(2);
        en_sclk_i = 1'b0;
        step(1);
        chk("abort_hold", outs(), 4'b1001);
        step(1);
        chk("abort_fall", outs(), 4'b0000);
        step(1);
        chk("abort_idle", outs(), 4'b0000);
        // drop in LOW, re-assert one cycle later
        en_sclk_i = 1'b1;
        step(2);
        chk("low_busy", outs(), 4'b0001);
        en_sclk_i = 1'b0;
        step(1);
        chk("low_drop", outs(), 4'b0000);
        step(1);
        en_sclk_i = 1'b1;
        step(4);
        chk("reassert_low", outs(), 4'b0001);
        step(1);
        chk("reassert_pos", outs(), 4'b1101);
        // reset while sclk high
        step(1);
        rst_i = 1'b0;
        step(1);
        chk("rst_high", outs(), 4'b0000);
        rst_i = 1'b1;
        en_sclk_i = 1'b0;
        step(1);
        chk("rst_after", outs(), 4'b0000);
`ifdef SPI_SCLK_CPOL_EN
        cpol_i = 1'b1;
        step(2);
        chk("cpol_idle", outs(), 4'b1000);
        en_sclk_i = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            step(1);
            if (i == 2) cpol_i = 1'b0;
            e[3] = !(i >= 5 && ((i - 5) % 8) < 4);
            e[2] = i >= 5 && ((i - 5) % 8) == 0;
            e[1] = i >= 9 && ((i - 9) % 8) == 0;
            e[0] = 1'b1;
            chk("cpol_run", outs(), e);
        end
        cpol_i = 1'b1;
        en_sclk_i = 1'b0;
        step(3);
        chk("cpol_park", outs(), 4'b1000);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
